// File: rtl/mc_controller.sv
// rtl/mc_controller.sv - multi-cycle MIPS control FSM sequencing the shared datapath
// Optional MC_PERF_CNT_EN adds live cycle/instruction counters (ports tie to 0 otherwise).
module mc_controller #(
  parameter logic [3:0] MEM_WAIT_MAX = 4'd15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  func,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        ir_write,
  output logic        pc_write,
  output logic [1:0]  next_pc_op,
  output logic        reg_write,
  output logic [1:0]  reg_addr_op,
  output logic [1:0]  reg_data_op,
  output logic [2:0]  alu_op,
  output logic [1:0]  alu_b_op,
  output logic        mem_write,
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        timeout,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instr_cnt
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC     = 4'd2,
    S_ALU_WB   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR
  } class_t;

  state_t     r_state;
  class_t     r_class;
  logic [3:0] r_wait;

  class_t     w_dec_class;
  logic       w_mem_state;
  logic       w_mem_tmo;

  always_comb begin
    w_dec_class = C_NOP;
    case (opcode)
      6'h00: begin
        case (func)
          6'h21:   w_dec_class = C_ADDU;
          6'h23:   w_dec_class = C_SUBU;
          6'h08:   w_dec_class = C_JR;
          default: w_dec_class = C_NOP;
        endcase
      end
      6'h0D:   w_dec_class = C_ORI;
      6'h0F:   w_dec_class = C_LUI;
      6'h23:   w_dec_class = C_LW;
      6'h2B:   w_dec_class = C_SW;
      6'h04:   w_dec_class = C_BEQ;
      6'h02:   w_dec_class = C_J;
      6'h03:   w_dec_class = C_JAL;
      default: w_dec_class = C_NOP;
    endcase
  end

  // Ready on the limit cycle takes priority, so timeout requires mem_ready low.
  assign w_mem_state = (r_state == S_MEM_RD) || (r_state == S_MEM_WR);
  assign w_mem_tmo   = w_mem_state && !mem_ready && (r_wait == MEM_WAIT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_class <= C_NOP;
      r_wait  <= 4'd0;
    end else begin
      case (r_state)
        S_FETCH:  r_state <= S_DECODE;
        S_DECODE: begin
          r_class <= w_dec_class;
          case (w_dec_class)
            C_ADDU, C_SUBU, C_ORI, C_LUI: r_state <= S_EXEC;
            C_LW, C_SW:                   r_state <= S_MEM_ADDR;
            C_BEQ:                        r_state <= S_BRANCH;
            C_J, C_JAL, C_JR:             r_state <= S_JUMP;
            default:                      r_state <= S_FETCH;
          endcase
        end
        S_EXEC:     r_state <= S_ALU_WB;
        S_MEM_ADDR: r_state <= (r_class == C_LW) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD, S_MEM_WR: begin
          if (mem_ready) begin
            r_state <= (r_state == S_MEM_RD) ? S_MEM_WB : S_FETCH;
            r_wait  <= 4'd0;
          end else if (r_wait == MEM_WAIT_MAX) begin
            r_state <= S_FETCH;
            r_wait  <= 4'd0;
          end else begin
            r_wait  <= r_wait + 4'd1;
          end
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign state = r_state;

  always_comb begin
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    next_pc_op  = 2'd0;
    reg_write   = 1'b0;
    reg_addr_op = 2'd0;
    reg_data_op = 2'd0;
    alu_op      = 3'd0;
    alu_b_op    = 2'd0;
    mem_write   = 1'b0;
    instr_done  = 1'b0;
    timeout     = 1'b0;
    if (!reset) begin
      case (r_state)
        S_FETCH: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        S_DECODE: instr_done = (w_dec_class == C_NOP);
        S_EXEC: begin
          case (r_class)
            C_SUBU: alu_op = 3'd1;
            C_ORI: begin
              alu_op   = 3'd2;
              alu_b_op = 2'd1;
            end
            C_LUI: begin
              alu_op   = 3'd3;
              alu_b_op = 2'd1;
            end
            default: alu_op = 3'd0;
          endcase
        end
        S_ALU_WB: begin
          reg_write   = 1'b1;
          reg_addr_op = ((r_class == C_ADDU) || (r_class == C_SUBU)) ? 2'd1 : 2'd0;
          instr_done  = 1'b1;
        end
        S_MEM_ADDR: alu_b_op = 2'd2;
        S_MEM_RD:   timeout = w_mem_tmo;
        S_MEM_WR: begin
          mem_write  = !w_mem_tmo;
          instr_done = mem_ready;
          timeout    = w_mem_tmo;
        end
        S_MEM_WB: begin
          reg_write   = 1'b1;
          reg_data_op = 2'd1;
          instr_done  = 1'b1;
        end
        S_BRANCH: begin
          alu_op     = 3'd1;
          next_pc_op = 2'd1;
          pc_write   = zero;
          instr_done = 1'b1;
        end
        S_JUMP: begin
          pc_write   = 1'b1;
          instr_done = 1'b1;
          case (r_class)
            C_JR: next_pc_op = 2'd3;
            C_JAL: begin
              next_pc_op  = 2'd2;
              reg_write   = 1'b1;
              reg_addr_op = 2'd2;
              reg_data_op = 2'd2;
            end
            default: next_pc_op = 2'd2;
          endcase
        end
        default: ir_write = 1'b0;
      endcase
    end
  end

`ifdef MC_PERF_CNT_EN
  logic [31:0] r_cycle_cnt;
  logic [31:0] r_instr_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle_cnt <= 32'd0;
      r_instr_cnt <= 32'd0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + 32'd1;
      r_instr_cnt <= r_instr_cnt + {31'd0, instr_done};
    end
  end

  assign cycle_cnt = r_cycle_cnt;
  assign instr_cnt = r_instr_cnt;
`else
  assign cycle_cnt = 32'd0;
  assign instr_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_mc_controller.sv
// tb/tb_mc_controller.sv - scoreboard bench for mc_controller
// Stimulus queues per-cycle expected outputs; a negedge monitor pops and compares.
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        zero;
  logic        mem_ready;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  next_pc_op;
  logic        reg_write;
  logic [1:0]  reg_addr_op;
  logic [1:0]  reg_data_op;
  logic [2:0]  alu_op;
  logic [1:0]  alu_b_op;
  logic        mem_write;
  logic [3:0]  state;
  logic        instr_done;
  logic        timeout;
  logic [31:0] cycle_cnt;
  logic [31:0] instr_cnt;

  mc_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write),
    .next_pc_op(next_pc_op), .reg_write(reg_write), .reg_addr_op(reg_addr_op),
    .reg_data_op(reg_data_op), .alu_op(alu_op), .alu_b_op(alu_b_op),
    .mem_write(mem_write), .state(state), .instr_done(instr_done),
    .timeout(timeout), .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
  );

  always #5 clk = ~clk;

  logic [20:0] exp_q[$];
  logic [63:0] perf_q[$];
  string       name_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_cyc = 32'd0;
  logic [31:0] m_ins = 32'd0;

  function automatic logic [20:0] mk(input int ir, input int pc, input int npc,
                                     input int rw, input int ra, input int rd,
                                     input int alu, input int ab, input int mw,
                                     input int st, input int dn, input int to);
    mk = {ir[0], pc[0], npc[1:0], rw[0], ra[1:0], rd[1:0], alu[2:0], ab[1:0],
          mw[0], st[3:0], dn[0], to[0]};
  endfunction

  task automatic step(input logic [20:0] e, input string nm);
    exp_q.push_back(e);
    name_q.push_back(nm);
`ifdef MC_PERF_CNT_EN
    perf_q.push_back({m_cyc, m_ins});
`else
    perf_q.push_back(64'd0);
`endif
    if (reset) begin
      m_cyc = 32'd0;
      m_ins = 32'd0;
    end else begin
      m_cyc = m_cyc + 32'd1;
      m_ins = m_ins + 32'(e[1]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic insn(input logic [5:0] op, input logic [5:0] fn, input int unk);
    opcode = op;
    func   = fn;
    step(mk(1,1,0,0,0,0,0,0,0,0,0,0), "fetch");
    step(mk(0,0,0,0,0,0,0,0,0,1,unk,0), "decode");
  endtask

  logic [20:0] mon_exp;
  logic [20:0] mon_got;
  logic [63:0] mon_pexp;
  string       mon_nm;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_pexp = perf_q.pop_front();
      mon_nm   = name_q.pop_front();
      mon_got  = {ir_write, pc_write, next_pc_op, reg_write, reg_addr_op, reg_data_op,
                  alu_op, alu_b_op, mem_write, state, instr_done, timeout};
      n_tests++;
      if (mon_got !== mon_exp) begin
        n_fail++;
        $display("FAIL %s outputs: got %b want %b (t=%0t)", mon_nm, mon_got, mon_exp, $time);
      end
      n_tests++;
      if ({cycle_cnt, instr_cnt} !== mon_pexp) begin
        n_fail++;
        $display("FAIL %s perf: got cyc=%0d ins=%0d want cyc=%0d ins=%0d", mon_nm,
                 cycle_cnt, instr_cnt, mon_pexp[63:32], mon_pexp[31:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; opcode = 6'd0; func = 6'd0; zero = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(mk(0,0,0,0,0,0,0,0,0,0,0,0), "reset_hold");
    reset = 1'b0;

    insn(6'h00, 6'h21, 0);
    step(mk(0,0,0,0,0,0,0,0,0,2,0,0), "addu_exec");
    step(mk(0,0,0,1,1,0,0,0,0,3,1,0), "addu_wb");

    insn(6'h00, 6'h23, 0);
    step(mk(0,0,0,0,0,0,1,0,0,2,0,0), "subu_exec");
    step(mk(0,0,0,1,1,0,0,0,0,3,1,0), "subu_wb");

    insn(6'h0D, 6'h00, 0);
    step(mk(0,0,0,0,0,0,2,1,0,2,0,0), "ori_exec");
    step(mk(0,0,0,1,0,0,0,0,0,3,1,0), "ori_wb");

    insn(6'h0F, 6'h21, 0);
    step(mk(0,0,0,0,0,0,3,1,0,2,0,0), "lui_exec");
    step(mk(0,0,0,1,0,0,0,0,0,3,1,0), "lui_wb");

    insn(6'h23, 6'h00, 0);
    step(mk(0,0,0,0,0,0,0,2,0,4,0,0), "lw_addr");
    for (int i = 0; i < 3; i++) step(mk(0,0,0,0,0,0,0,0,0,5,0,0), "lw_wait");
    mem_ready = 1'b1;
    step(mk(0,0,0,0,0,0,0,0,0,5,0,0), "lw_ready");
    mem_ready = 1'b0;
    step(mk(0,0,0,1,0,1,0,0,0,6,1,0), "lw_wb");

    zero = 1'b1;
    insn(6'h04, 6'h00, 0);
    step(mk(0,1,1,0,0,0,1,0,0,8,1,0), "beq_taken");
    zero = 1'b0;
    insn(6'h04, 6'h00, 0);
    step(mk(0,0,1,0,0,0,1,0,0,8,1,0), "beq_not_taken");

    insn(6'h02, 6'h00, 0);
    step(mk(0,1,2,0,0,0,0,0,0,9,1,0), "j_jump");
    insn(6'h03, 6'h00, 0);
    step(mk(0,1,2,1,2,2,0,0,0,9,1,0), "jal_jump");
    insn(6'h00, 6'h08, 0);
    step(mk(0,1,3,0,0,0,0,0,0,9,1,0), "jr_jump");

    insn(6'h3F, 6'h00, 1);
    insn(6'h00, 6'h00, 1);

    insn(6'h2B, 6'h00, 0);
    step(mk(0,0,0,0,0,0,0,2,0,4,0,0), "sw_addr");
    for (int i = 0; i < 15; i++) step(mk(0,0,0,0,0,0,0,0,1,7,0,0), "sw_wait");
    step(mk(0,0,0,0,0,0,0,0,0,7,0,1), "sw_timeout");

    insn(6'h2B, 6'h00, 0);
    step(mk(0,0,0,0,0,0,0,2,0,4,0,0), "sw2_addr");
    for (int i = 0; i < 15; i++) step(mk(0,0,0,0,0,0,0,0,1,7,0,0), "sw2_wait");
    mem_ready = 1'b1;
    step(mk(0,0,0,0,0,0,0,0,1,7,1,0), "sw2_ready_at_limit");
    mem_ready = 1'b0;

    insn(6'h23, 6'h00, 0);
    step(mk(0,0,0,0,0,0,0,2,0,4,0,0), "lw2_addr");
    for (int i = 0; i < 15; i++) step(mk(0,0,0,0,0,0,0,0,0,5,0,0), "lw2_wait");
    step(mk(0,0,0,0,0,0,0,0,0,5,0,1), "lw2_timeout");

    insn(6'h2B, 6'h00, 0);
    step(mk(0,0,0,0,0,0,0,2,0,4,0,0), "sw3_addr");
    step(mk(0,0,0,0,0,0,0,0,1,7,0,0), "sw3_wait");
    reset = 1'b1;
    step(mk(0,0,0,0,0,0,0,0,0,7,0,0), "sw3_reset");
    reset = 1'b0;

    insn(6'h00, 6'h21, 0);
    step(mk(0,0,0,0,0,0,0,0,0,2,0,0), "addu2_exec");
    step(mk(0,0,0,1,1,0,0,0,0,3,1,0), "addu2_wb");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
- Multi-cycle control FSM that sequences the shared MIPS datapath: one ALU, one memory port and one register file, reused across the states of each instruction.
- Takes opcode/func from the instruction register plus the ALU zero flag.
- Drives the per-state write enables and mux selects into DATAPATH.
- Replaces the single-cycle CU when the core moves to multi-cycle execution.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles spent in a memory state waiting for mem_ready before timeout to FETCH; width 4 bits.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- opcode  input  6  instr[31:26], stable from DECODE to end of instruction
- func  input  6  instr[5:0]
- zero  input  1  ALU equality flag (valid in BRANCH)
- mem_ready  input  1  data memory handshake, sampled in MEM_RD/MEM_WR
- ir_write  output  1  load instruction register
- pc_write  output  1  load PC
- next_pc_op  output  2  0 pc+4, 1 branch target, 2 j_address, 3 GPR[rs]
- reg_write  output  1  GRF write enable
- reg_addr_op  output  2  0 rt, 1 rd, 2 $31
- reg_data_op  output  2  0 ALU result, 1 memory data, 2 pc (already +4)
- alu_op  output  3  0 add, 1 sub, 2 or, 3 lui
- alu_b_op  output  2  0 GPR[rt], 1 zero-ext imm, 2 sign-ext imm
- mem_write  output  1  data memory write enable
- state  output  4  current state encoding, for debug
- instr_done  output  1  one-cycle pulse on the last cycle of every instruction
- timeout  output  1  one-cycle pulse when the memory wait expires

Behaviour:
- Outputs are Moore: decoded from the state register and the latched class register only.
- Exceptions to the Moore rule: pc_write in BRANCH also depends on zero, and MEM_WR/MEM_RD exits depend on mem_ready.
- States: FETCH=0, DECODE=1, EXEC=2, ALU_WB=3, MEM_ADDR=4, MEM_RD=5, MEM_WB=6, MEM_WR=7, BRANCH=8, JUMP=9.
- Reset: next edge sets state to FETCH, class to NOP and wait counter to 0. While reset is high, every enable output is forced to 0, as are instr_done and timeout.
- FETCH: ir_write=1, pc_write=1, next_pc_op=0. Goes to DECODE.
- DECODE: latches class from opcode/func.
  - addu (0/0x21), subu (0/0x23): go to EXEC.
  - ori (0x0D), lui (0x0F): go to EXEC.
  - lw (0x23), sw (0x2B): go to MEM_ADDR.
  - beq (0x04): go to BRANCH.
  - j (0x02), jal (0x03), jr (0/0x08): go to JUMP.
  - Anything else, including nop: instr_done=1, back to FETCH.
- EXEC: alu_op and alu_b_op per class.
  - addu: alu_op 0, alu_b_op 0.
  - subu: alu_op 1, alu_b_op 0.
  - ori: alu_op 2, alu_b_op 1.
  - lui: alu_op 3, alu_b_op 1.
  - Goes to ALU_WB.
- ALU_WB: reg_write=1, reg_data_op=0, reg_addr_op=1 for R-type, 0 for I-type. instr_done=1, then FETCH.
- MEM_ADDR: alu_op 0, alu_b_op 2. lw goes to MEM_RD; sw goes to MEM_WR.
- MEM_WR: mem_write=1 while in state. Exits to FETCH with instr_done=1 in the cycle mem_ready=1.
- MEM_RD: holds until mem_ready=1, then goes to MEM_WB.
- MEM_WB: reg_write=1, reg_data_op=1, reg_addr_op=0. instr_done=1, then FETCH.
- Memory wait: counter increments each cycle in MEM_RD/MEM_WR with mem_ready=0. When it reaches MEM_WAIT_MAX with mem_ready still 0, pulse timeout and go to FETCH with no register or memory write that cycle; the instruction is abandoned and no instr_done is pulsed. Counter clears on leaving the state.
- mem_ready=1 on the same cycle the counter hits the limit: ready wins, no timeout.
- BRANCH: alu_op 1, alu_b_op 0, next_pc_op 1, pc_write=zero. instr_done=1, then FETCH.
- JUMP:
  - pc_write=1.
  - next_pc_op 2 for j/jal, 3 for jr.
  - For jal additionally reg_write=1, reg_addr_op 2, reg_data_op 2.
  - instr_done=1, then FETCH.
- Latency in cycles: R/ori/lui 4; sw 4+waits; lw 5+waits; beq 3; j/jal/jr 3; unknown 2.
- Reset mid-instruction: abandoned immediately, with no partial write on the reset cycle.
- Unused select outputs read 0 in every state.

Optional Feature:
- MC_PERF_CNT_EN: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt counts every non-reset cycle.
  - instr_cnt counts instr_done pulses.
  - Both clear on reset and wrap at 2^32.
- Without the macro, the ports still exist and are tied to 0.

Test Plan:
- Reset held 2 cycles, then released; addu opcode 0/func 0x21 -> state 0,1,2,3,0; reg_write=1, reg_addr_op=1 only in cycle 4; instr_done pulses once.
- lw with mem_ready low 3 cycles then high -> MEM_RD held 4 cycles; MEM_WB asserts reg_data_op=1; total 8 cycles.
- beq with zero=1 -> pc_write=1 and next_pc_op=1 in BRANCH; repeated with zero=0 -> pc_write=0; both take 3 cycles.
- jal -> JUMP asserts pc_write=1, next_pc_op=2, reg_write=1, reg_addr_op=2, reg_data_op=2.
- sw with mem_ready stuck low -> after 15 waits timeout pulses, mem_write drops, state returns to 0, no instr_done; a second case with ready arriving on the 15th wait completes normally.
- Reset asserted while in MEM_WR -> mem_write 0 that cycle, state 0 after the edge; with MC_PERF_CNT_EN, both counters read 0.
